pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Sequences the board PLL from reset to locked operation. It drives the PLL `reset` input, synchronizes and qualifies the PLL `lock` output, and bounds lock acquisition with a timeout and retry budget. It publishes a single `ready_o` qualifier that the system reset tree uses to release the clock domains fed by the PLL outputs. It runs on the 50 MHz board input clock that also feeds the PLL `clkin`, so it never depends on a PLL output clock.

## Interface
Parameters:
- `RESET_CYCLES`, default 64: clk cycles that `pll_reset_o` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, default 50000: clk cycles allowed in WAIT_LOCK before the attempt fails (≥1).
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, default 3: failed attempts tolerated before FAULT (1..15).

Ports:
- `clk`  in  1  50 MHz board clock, same net as PLL `clkin`.
- `rst_n`  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is used on the next `clk` edge.
- `pll_lock_i`  in  1  raw PLL `lock`, asynchronous to `clk`.
- `force_relock_i`  in  1  single-cycle request to restart the sequence from any state.
- `pll_reset_o`  out  1  drives PLL `reset`; 1 = PLL held in reset.
- `ready_o`  out  1  1 only in RUN.
- `fault_o`  out  1  1 only in FAULT.
- `retry_count_o`  out  4  failed attempts in the current sequence.
- `state_o`  out  3  encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.

## Operation
- `pll_lock_i` passes through a 2-flop synchronizer (`lock_s`). All decisions use `lock_s`.
- A single down-counter, sized `$clog2(max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1)`, is reloaded on every state entry.
- RESET: `pll_reset_o`=1. After `RESET_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_reset_o`=0.
  - `lock_s`=1: go to STABLE.
  - `LOCK_TIMEOUT` cycles elapse without lock: increment `retry_count`. If the new value equals `MAX_RETRIES`, go to FAULT; otherwise go to RESET.
- STABLE:
  - `lock_s` stays 1 for `STABLE_CYCLES` consecutive cycles: go to RUN and clear `retry_count`.
  - `lock_s` drops: return to WAIT_LOCK with the timeout counter reloaded. This is not counted as a retry.
- RUN: `ready_o`=1. Behaviour on `lock_s` falling is set by the macro in Configuration.
- FAULT: `pll_reset_o`=1, `fault_o`=1. Only `force_relock_i` or `rst_n` exits this state.
- `force_relock_i`=1 in any state: next state is RESET, `retry_count` and `fault_o` clear. It has priority over every other transition in the same cycle (timeout, lock change).
- `retry_count` saturates at `MAX_RETRIES` and never wraps.
- Outputs are registered and decoded from the state register. No output is combinational from an input.

## Timing
- Reset values while `rst_n`=0: state=RESET, `pll_reset_o`=1, `ready_o`=0, `fault_o`=0, `retry_count_o`=0, synchronizer flops=0, counter=`RESET_CYCLES`.
- After the first `clk` edge with `rst_n`=1: `pll_reset_o` stays 1 for exactly `RESET_CYCLES` edges.
- Raw lock rising at edge t: `lock_s`=1 at t+2. STABLE is entered at t+3. `ready_o` rises at t+3+`STABLE_CYCLES`.
- Lock loss in RUN (raw falls at edge t): `ready_o` falls at t+3. Worst-case deassert latency is 3 clk (60 ns).
- `rst_n` asserted mid-sequence: all outputs take reset values immediately (asynchronous), with no glitch on `pll_reset_o`, which is already 1.

## Configuration
- `PLL_SEQ_AUTO_RELOCK_EN` defined: lock loss in RUN goes to RESET. `retry_count` starts from 0 and the full sequence repeats without software intervention.
- `PLL_SEQ_AUTO_RELOCK_EN` undefined: lock loss in RUN goes directly to FAULT (`fault_o`=1, `pll_reset_o`=1, `retry_count_o` unchanged). Recovery requires `force_relock_i` or `rst_n`.

## Test plan
Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.

1. Clean bring-up: release `rst_n`, raise `pll_lock_i` 10 cycles later. Expect `pll_reset_o`=1 for 4 cycles, `ready_o` rising 11 cycles after the lock edge, `retry_count_o`=0.
2. Exhausted retries: hold `pll_lock_i`=0. Expect two RESET(4)+WAIT_LOCK(20) rounds, `retry_count_o` reaching 1 then 2, then FAULT with `fault_o`=1 and `pll_reset_o`=1.
3. Lock glitch in STABLE: drop `pll_lock_i` for 1 cycle 5 cycles into STABLE. Expect a return to WAIT_LOCK, `retry_count_o` still 0, and `ready_o` only after 8 fresh consecutive stable cycles.
4. Loss in RUN: drop `pll_lock_i`. Expect `ready_o`=0 within 3 cycles. With the macro: state returns to RESET. Without the macro: FAULT is entered and held.
5. Force during timeout: pulse `force_relock_i` on the same edge as WAIT_LOCK expiry on the second attempt. Expect RESET, `retry_count_o`=0, `fault_o` never asserted.
6. Async reset mid-STABLE: assert `rst_n`=0 between clock edges. Expect all outputs at reset values before the next edge, and the sequence restarting from RESET after release.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, synchronized lock qualification, timeout/retry, fault.
// Latency: lock edge to ready_o = 3 + STABLE_CYCLES clk; lock loss to ready_o low = 3 clk.
// Backpressure: none; force_relock_i restarts at once. Macro PLL_SEQ_AUTO_RELOCK_EN selects relock on loss in RUN.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       force_relock_i,
  output logic       pll_reset_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [3:0] retry_count_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_MAX =
    (RESET_CYCLES > LOCK_TIMEOUT)
      ? ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES)
      : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LD    = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] TO_LD     = CW'(LOCK_TIMEOUT);
  localparam logic [CW-1:0] STB_LD    = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    retry_nxt;
  logic          sync_q, lock_s;
  logic          cnt_last;

  // Raw lock is asynchronous to clk; two flops before any decision uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync_q <= pll_lock_i;
      lock_s <= sync_q;
    end
  end

  assign cnt_last = (cnt == CNT_ONE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_count_o;
    if (force_relock_i) begin
      state_nxt = S_RESET;
      cnt_nxt   = RST_LD;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_RESET: begin
          if (cnt_last) begin
            state_nxt = S_WAIT;
            cnt_nxt   = TO_LD;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        S_WAIT: begin
          // Lock seen on the expiry cycle still counts as acquired.
          if (lock_s) begin
            state_nxt = S_STABLE;
            cnt_nxt   = STB_LD;
          end else if (cnt_last) begin
            retry_nxt = (retry_count_o >= RETRY_MAX) ? RETRY_MAX : retry_count_o + 4'd1;
            if (retry_nxt == RETRY_MAX) begin
              state_nxt = S_FAULT;
            end else begin
              state_nxt = S_RESET;
              cnt_nxt   = RST_LD;
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_nxt = S_WAIT;
            cnt_nxt   = TO_LD;
          end else if (cnt_last) begin
            state_nxt = S_RUN;
            retry_nxt = 4'd0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            state_nxt = S_RESET;
            cnt_nxt   = RST_LD;
            retry_nxt = 4'd0;
`else
            state_nxt = S_FAULT;
`endif
          end
        end
        S_FAULT: begin
          state_nxt = S_FAULT;
        end
        default: begin
          state_nxt = S_RESET;
          cnt_nxt   = RST_LD;
          retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip together with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET;
      cnt           <= RST_LD;
      retry_count_o <= 4'd0;
      pll_reset_o   <= 1'b1;
      ready_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      retry_count_o <= retry_nxt;
      pll_reset_o   <= (state_nxt == S_RESET) || (state_nxt == S_FAULT);
      ready_o       <= (state_nxt == S_RUN);
      fault_o       <= (state_nxt == S_FAULT);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: timeline model for random lock arrival plus directed corner cases.
module tb_pll_lock_sequencer;
  localparam int R = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int M = 2;
  localparam int P = R + T;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock_i;
  logic       force_relock_i;
  logic       pll_reset_o;
  logic       ready_o;
  logic       fault_o;
  logic [3:0] retry_count_o;
  logic [2:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  pll_lock_sequencer #(
    .RESET_CYCLES (R),
    .LOCK_TIMEOUT (T),
    .STABLE_CYCLES(S),
    .MAX_RETRIES  (M)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock_i    (pll_lock_i),
    .force_relock_i(force_relock_i),
    .pll_reset_o   (pll_reset_o),
    .ready_o       (ready_o),
    .fault_o       (fault_o),
    .retry_count_o (retry_count_o),
    .state_o       (state_o)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish before 400us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 8'(state_o), 8'd0);
    chk({tag, "_pllrst"}, 8'(pll_reset_o), 8'd1);
    chk({tag, "_ready"}, 8'(ready_o), 8'd0);
    chk({tag, "_fault"}, 8'(fault_o), 8'd0);
    chk({tag, "_retry"}, 8'(retry_count_o), 8'd0);
  endtask

  // Attempt index in whose wait window the synchronized lock is first seen (M means never).
  function automatic int attempt_of(input int t);
    int k = 0;
    while ((k + 1) * P < t + 3 && k < M) k++;
    return k;
  endfunction

  function automatic int stable_entry(input int t, input int k);
    int a = t + 3;
    int b = k * P + R + 1;
    return (a > b) ? a : b;
  endfunction

  // Expected outputs c edges after release, given attempt k and STABLE entry edge s.
  task automatic chk_model(input int c, input int k, input int s);
    int est, eret, lim;
    bit flt = (k >= M);
    if (flt && c >= M * P)        est = 4;
    else if (!flt && c >= s + S)  est = 3;
    else if (!flt && c >= s)      est = 2;
    else if ((c % P) < R)         est = 0;
    else                          est = 1;
    lim  = flt ? M : k;
    eret = (est == 3) ? 0 : (((c / P) < lim) ? (c / P) : lim);
    chk($sformatf("c%0d_state", c), 8'(state_o), 8'(est));
    chk($sformatf("c%0d_ready", c), 8'(ready_o), 8'(est == 3));
    chk($sformatf("c%0d_fault", c), 8'(fault_o), 8'(est == 4));
    chk($sformatf("c%0d_pllrst", c), 8'(pll_reset_o), 8'(est == 0 || est == 4));
    chk($sformatf("c%0d_retry", c), 8'(retry_count_o), 8'(eret));
  endtask

  task automatic restart();
    rst_n = 1'b0;
    pll_lock_i = 1'b0;
    force_relock_i = 1'b0;
    tick();
    tick();
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_trial(input int t);
    int k = attempt_of(t);
    int s = stable_entry(t, k);
    restart();
    chk_model(0, k, s);
    for (int c = 1; c <= 70; c++) begin
      if (c == t + 1) pll_lock_i = 1'b1;
      tick();
      chk_model(c, k, s);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_lock_i = 1'b0;
    force_relock_i = 1'b0;

    // Clean bring-up with lock 10 edges after release, then random arrivals incl. exhausted retries.
    run_trial(10);
    run_trial(60);
    for (int i = 0; i < 5; i++) run_trial(int'($urandom_range(1, 60)));

    // One-cycle lock glitch 5 edges into STABLE (lock at 6, STABLE at 9).
    restart();
    while (cyc < 6) tick();
    pll_lock_i = 1'b1;
    while (cyc < 14) tick();
    chk("glitch_pre_state", 8'(state_o), 8'd2);
    pll_lock_i = 1'b0;
    tick();
    pll_lock_i = 1'b1;
    tick();
    chk("glitch_c16_state", 8'(state_o), 8'd2);
    tick();
    chk("glitch_wait_state", 8'(state_o), 8'd1);
    chk("glitch_retry", 8'(retry_count_o), 8'd0);
    tick();
    chk("glitch_restable", 8'(state_o), 8'd2);
    while (cyc < 25) begin
      tick();
      chk($sformatf("glitch_c%0d_ready", cyc), 8'(ready_o), 8'd0);
    end
    tick();
    chk("glitch_ready", 8'(ready_o), 8'd1);
    chk("glitch_run_retry", 8'(retry_count_o), 8'd0);

    // Lock loss in RUN at edge 28.
    tick();
    tick();
    pll_lock_i = 1'b0;
    tick();
    chk("loss_c1_ready", 8'(ready_o), 8'd1);
    tick();
    chk("loss_c2_ready", 8'(ready_o), 8'd1);
    tick();
    chk("loss_ready", 8'(ready_o), 8'd0);
    chk("loss_pllrst", 8'(pll_reset_o), 8'd1);
    chk("loss_retry", 8'(retry_count_o), 8'd0);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    chk("loss_state", 8'(state_o), 8'd0);
    chk("loss_fault", 8'(fault_o), 8'd0);
    for (int i = 0; i < R; i++) tick();
    chk("relock_wait", 8'(state_o), 8'd1);
`else
    chk("loss_state", 8'(state_o), 8'd4);
    chk("loss_fault", 8'(fault_o), 8'd1);
    pll_lock_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("fault_hold%0d", i), 8'(state_o), 8'd4);
    end
`endif
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    chk("force_exit_state", 8'(state_o), 8'd0);
    chk("force_exit_fault", 8'(fault_o), 8'd0);
    chk("force_exit_pllrst", 8'(pll_reset_o), 8'd1);

    // Force coinciding with the second timeout (edge 2P).
    restart();
    while (cyc < 2 * P - 1) tick();
    chk("ft_pre_retry", 8'(retry_count_o), 8'd1);
    chk("ft_pre_state", 8'(state_o), 8'd1);
    force_relock_i = 1'b1;
    tick();
    force_relock_i = 1'b0;
    chk("ft_state", 8'(state_o), 8'd0);
    chk("ft_retry", 8'(retry_count_o), 8'd0);
    chk("ft_fault", 8'(fault_o), 8'd0);
    for (int i = 1; i <= P; i++) begin
      tick();
      chk($sformatf("ft_nofault%0d", i), 8'(fault_o), 8'd0);
    end
    chk("ft_next_retry", 8'(retry_count_o), 8'd1);
    chk("ft_next_state", 8'(state_o), 8'd0);

    // Asynchronous reset between edges while in STABLE, then restart with lock already high.
    restart();
    while (cyc < 3) tick();
    pll_lock_i = 1'b1;
    while (cyc < 9) tick();
    chk("async_pre_state", 8'(state_o), 8'd2);
    #4;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    tick();
    rst_n = 1'b1;
    cyc = 0;
    chk_model(0, 0, R + 1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk_model(c, 0, R + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
